// File: rtl/fake_mario_pio_pkg.sv
// Shared constants for the fake_mario input PIO: Avalon register addresses
// and the encodings of the EDGE_TYPE parameter.
package fake_mario_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/fake_mario_debounce.sv
// One input bit: SYNC_STAGES-deep synchroniser followed by an optional
// stability-counter debouncer (DEBOUNCE_CYCLES = 0 bypasses it).
module fake_mario_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign dout = sync_out;
        end else begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt_q;
            logic          deb_q;

            // The counter only advances while the synchronised input disagrees
            // with the debounced value; any agreeing cycle restarts the count.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                    deb_q <= 1'b0;
                end else if (sync_out == deb_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_q <= '0;
                    deb_q <= ~deb_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign dout = deb_q;
        end
    endgenerate

endmodule

// File: rtl/fake_mario_input_pio.sv
// Avalon-MM input PIO: synchronised/debounced inputs, edge capture with
// write-1-to-clear, interrupt mask and a level interrupt.
module fake_mario_input_pio
    import fake_mario_pio_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_prev;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] wdata;
    logic             wr_en;
    logic             wdata_unused;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            fake_mario_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk     (clk),
                .reset_n (reset_n),
                .din     (in_port[i]),
                .dout    (deb[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_prev <= '0;
        end else begin
            deb_prev <= deb;
        end
    end

    generate
        if (EDGE_TYPE == EDGE_RISING) begin : g_rise
            assign edge_det = deb & ~deb_prev;
        end else if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
            assign edge_det = ~deb & deb_prev;
        end else begin : g_any
            assign edge_det = deb ^ deb_prev;
        end
    endgenerate

    assign wr_en        = chipselect && !write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign wdata_unused = ^writedata;
    assign edge_clr     = (wr_en && address == ADDR_EDGE) ? wdata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= '0;
        end else if (wr_en && address == ADDR_MASK) begin
            irqmask <= wdata;
        end
    end

    // A new edge is OR-ed in after the clear so a coincident edge survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecapture <= '0;
        end else begin
            edgecapture <= (edgecapture & ~edge_clr) | edge_det;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                ADDR_DATA: readdata <= 32'(deb);
                ADDR_MASK: readdata <= 32'(irqmask);
                ADDR_EDGE: readdata <= 32'(edgecapture);
                default:   readdata <= '0;
            endcase
        end
    end

    assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_fake_mario_input_pio.sv
// Directed bench: dut0 uses default parameters, dut1 adds a 4-cycle debounce.
// Both share the bus; each has its own input port and outputs.
module tb_fake_mario_input_pio;
    import fake_mario_pio_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [15:0] in0;
    logic [15:0] in1;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        irq0;
    logic        irq1;

    int tests_run    = 0;
    int tests_failed = 0;

    fake_mario_input_pio dut0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in0),
        .readdata   (rd0),
        .irq        (irq0)
    );

    fake_mario_input_pio #(
        .WIDTH           (16),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .EDGE_TYPE       (0)
    ) dut1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in1),
        .readdata   (rd1),
        .irq        (irq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a;
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        tests_run++;
        if (rd0 !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_rd0: got %h want %h", rd0, 32'h0);
        end
        tests_run++;
        if (rd1 !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_rd1: got %h want %h", rd1, 32'h0);
        end
        tests_run++;
        if (irq0 !== 1'b0 || irq1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_irq: got %b%b want 00", irq0, irq1);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_data_default;
        address = ADDR_DATA;
        in0 = 16'h00A5;
        repeat (2) @(negedge clk);
        tests_run++;
        if (rd0 !== 32'h0) begin
            tests_failed++;
            $display("FAIL data_early: got %h want %h", rd0, 32'h0);
        end
        @(negedge clk);
        tests_run++;
        if (rd0 !== 32'h0000_00A5) begin
            tests_failed++;
            $display("FAIL data_latency: got %h want %h", rd0, 32'h0000_00A5);
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if (rd0 !== 32'h0000_00A5) begin
            tests_failed++;
            $display("FAIL data_hold: got %h want %h", rd0, 32'h0000_00A5);
        end
        bus_read(ADDR_EDGE);
        tests_run++;
        if (rd0 !== 32'h0000_00A5) begin
            tests_failed++;
            $display("FAIL edge_a5: got %h want %h", rd0, 32'h0000_00A5);
        end
    endtask

    task automatic test_debounce;
        address = ADDR_DATA;
        in1 = 16'h0001;
        repeat (3) @(negedge clk);
        in1 = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tests_run++;
            if (rd1[0] !== 1'b0) begin
                tests_failed++;
                $display("FAIL glitch_data c%0d: got %b want 0", i, rd1[0]);
            end
        end
        bus_read(ADDR_EDGE);
        tests_run++;
        if (rd1 !== 32'h0) begin
            tests_failed++;
            $display("FAIL glitch_edge: got %h want %h", rd1, 32'h0);
        end
        address = ADDR_DATA;
        in1 = 16'h0001;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 6) begin
                tests_run++;
                if (rd1 !== 32'h0) begin
                    tests_failed++;
                    $display("FAIL deb_early: got %h want %h", rd1, 32'h0);
                end
            end
            if (i == 7) begin
                tests_run++;
                if (rd1 !== 32'h1) begin
                    tests_failed++;
                    $display("FAIL deb_latency: got %h want %h", rd1, 32'h1);
                end
            end
        end
        bus_read(ADDR_EDGE);
        tests_run++;
        if (rd1 !== 32'h1) begin
            tests_failed++;
            $display("FAIL deb_edge: got %h want %h", rd1, 32'h1);
        end
    endtask

    task automatic test_irq;
        bus_write(ADDR_EDGE, 32'h0000_FFFF);
        bus_write(ADDR_MASK, 32'h0000_0001);
        tests_run++;
        if (irq0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_idle: got %b want 0", irq0);
        end
        in0 = 16'h00A4;
        repeat (4) @(negedge clk);
        tests_run++;
        if (irq0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_fall: got %b want 0", irq0);
        end
        in0 = 16'h00A5;
        repeat (2) @(negedge clk);
        tests_run++;
        if (irq0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_early: got %b want 0", irq0);
        end
        @(negedge clk);
        tests_run++;
        if (irq0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL irq_rise: got %b want 1", irq0);
        end
        bus_read(ADDR_EDGE);
        tests_run++;
        if (rd0 !== 32'h1) begin
            tests_failed++;
            $display("FAIL irq_edge: got %h want %h", rd0, 32'h1);
        end
        bus_write(ADDR_EDGE, 32'h0000_0001);
        tests_run++;
        if (irq0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_clear: got %b want 0", irq0);
        end
        bus_read(ADDR_EDGE);
        tests_run++;
        if (rd0 !== 32'h0) begin
            tests_failed++;
            $display("FAIL edge_clear: got %h want %h", rd0, 32'h0);
        end
    endtask

    task automatic test_set_wins;
        in0 = 16'h00AD;
        repeat (2) @(negedge clk);
        bus_write(ADDR_EDGE, 32'h0000_0008);
        bus_read(ADDR_EDGE);
        tests_run++;
        if (rd0 !== 32'h8) begin
            tests_failed++;
            $display("FAIL set_wins: got %h want %h", rd0, 32'h8);
        end
        tests_run++;
        if (irq0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL set_wins_irq: got %b want 0", irq0);
        end
        bus_write(ADDR_EDGE, 32'h0000_0008);
        bus_read(ADDR_EDGE);
        tests_run++;
        if (rd0 !== 32'h0) begin
            tests_failed++;
            $display("FAIL bit3_clear: got %h want %h", rd0, 32'h0);
        end
    endtask

    task automatic test_mask;
        bus_write(ADDR_MASK, 32'h0);
        in0 = 16'h008D;
        repeat (4) @(negedge clk);
        in0 = 16'h00AD;
        repeat (4) @(negedge clk);
        tests_run++;
        if (irq0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL masked_irq: got %b want 0", irq0);
        end
        bus_read(ADDR_EDGE);
        tests_run++;
        if (rd0 !== 32'h20) begin
            tests_failed++;
            $display("FAIL edge_bit5: got %h want %h", rd0, 32'h20);
        end
        bus_write(ADDR_MASK, 32'hFFFF_0020);
        tests_run++;
        if (irq0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL unmask_irq: got %b want 1", irq0);
        end
        bus_read(ADDR_MASK);
        tests_run++;
        if (rd0 !== 32'h20) begin
            tests_failed++;
            $display("FAIL mask_read: got %h want %h", rd0, 32'h20);
        end
        bus_write(ADDR_DATA, 32'h0000_1234);
        bus_write(ADDR_RSVD, 32'hFFFF_FFFF);
        bus_read(ADDR_DATA);
        tests_run++;
        if (rd0 !== 32'hAD) begin
            tests_failed++;
            $display("FAIL data_ro: got %h want %h", rd0, 32'hAD);
        end
        bus_read(ADDR_RSVD);
        tests_run++;
        if (rd0 !== 32'h0) begin
            tests_failed++;
            $display("FAIL rsvd_read: got %h want %h", rd0, 32'h0);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_tbl [4];
        logic [1:0]  addr_tbl [4];
        addr_tbl = '{ADDR_DATA, ADDR_MASK, ADDR_EDGE, ADDR_RSVD};
        exp_tbl  = '{32'hAD, 32'h20, 32'h20, 32'h0};
        for (int i = 0; i < 4; i++) begin
            bus_read(addr_tbl[i]);
            tests_run++;
            if (rd0 !== exp_tbl[i]) begin
                tests_failed++;
                $display("FAIL b2b_read%0d: got %h want %h", i, rd0, exp_tbl[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        address = ADDR_DATA;
        in0 = 16'hFFFF;
        in1 = 16'hFFFF;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (rd0 !== 32'h0 || rd1 !== 32'h0) begin
            tests_failed++;
            $display("FAIL mid_reset_rd: got %h %h want 0 0", rd0, rd1);
        end
        tests_run++;
        if (irq0 !== 1'b0 || irq1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_irq: got %b%b want 00", irq0, irq1);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 2 && rd0 !== 32'h0) begin
                tests_failed++;
                $display("FAIL post_rst_d0_early: got %h want 0", rd0);
            end
            if (i == 3 && rd0 !== 32'hFFFF) begin
                tests_failed++;
                $display("FAIL post_rst_d0: got %h want %h", rd0, 32'hFFFF);
            end
            if (i == 6 && rd1 !== 32'h0) begin
                tests_failed++;
                $display("FAIL post_rst_d1_early: got %h want 0", rd1);
            end
            if (i == 7 && rd1 !== 32'hFFFF) begin
                tests_failed++;
                $display("FAIL post_rst_d1: got %h want %h", rd1, 32'hFFFF);
            end
            if (i == 2 || i == 3 || i == 6 || i == 7) tests_run++;
        end
        bus_read(ADDR_EDGE);
        tests_run++;
        if (rd0 !== 32'hFFFF || rd1 !== 32'hFFFF) begin
            tests_failed++;
            $display("FAIL post_rst_edge: got %h %h want ffff ffff", rd0, rd1);
        end
        bus_read(ADDR_MASK);
        tests_run++;
        if (rd0 !== 32'h0 || irq0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_rst_mask: got %h irq %b want 0 0", rd0, irq0);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = ADDR_DATA;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in0        = '0;
        in1        = '0;
        test_reset();
        test_data_default();
        test_debounce();
        test_irq();
        test_set_wins();
        test_mask();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
